// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StFetch = 2'b01,
      StIssue = 2'b10,
      StFault = 2'b11
   } fetch_state_t;

   typedef enum logic [1:0] {
      PCJ_SEQ  = 2'b00,
      PCJ_JMP  = 2'b01,
      PCJ_BR_T = 2'b10,
      PCJ_BR_F = 2'b11
   } pc_jmp_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch_next_pc.sv
// Combinational next-PC target selection and word-alignment check.
module instr_fetch_next_pc
   import instr_fetch_pkg::*;
(
   input  logic [31:0]        pc,
   input  pc_jmp_t            pc_jmp,
   input  logic signed [31:0] imm,
   input  logic               alu_flag,
   output logic [31:0]        target,
   output logic               target_misaligned
);

   logic        taken;
   logic [31:0] pc_imm;
   logic [31:0] pc_seq;

   assign pc_imm = pc + imm;
   assign pc_seq = pc + 32'd4;

   always_comb begin
      taken = 1'b0;
      unique case (pc_jmp)
         PCJ_SEQ:  taken = 1'b0;
         PCJ_JMP:  taken = 1'b1;
         PCJ_BR_T: taken = alu_flag;
         PCJ_BR_F: taken = ~alu_flag;
         default:  taken = 1'b0;
      endcase
   end

   assign target            = taken ? pc_imm : pc_seq;
   assign target_misaligned = |target[1:0];

endmodule

// File: rtl/instr_fetch.sv
// Multicycle fetch stage: owns the PC, fetches one word, holds it until retire.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_valid,
   input  logic [31:0]        imem_rdata,
   output logic [31:0]        instruction,
   output logic               instr_valid,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4,
   input  logic               stall,
   input  logic [1:0]         pc_jmp,
   input  logic signed [31:0] imm,
   input  logic               alu_flag,
   output logic               misaligned
);

   fetch_state_t state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         instr_valid_q, instr_valid_d;
   logic         imem_req_q, imem_req_d;
   logic         misaligned_q, misaligned_d;

   logic [31:0]  target;
   logic         target_misaligned;

   instr_fetch_next_pc u_next_pc (
      .pc                (pc_q),
      .pc_jmp            (pc_jmp_t'(pc_jmp)),
      .imm               (imm),
      .alu_flag          (alu_flag),
      .target            (target),
      .target_misaligned (target_misaligned)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      imem_req_d    = imem_req_q;
      misaligned_d  = misaligned_q;
      unique case (state_q)
         StIdle: begin
            state_d    = StFetch;
            imem_req_d = 1'b1;
         end
         StFetch: begin
            if (imem_valid) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               imem_req_d    = 1'b0;
               state_d       = StIssue;
            end
         end
         StIssue: begin
            if (!stall) begin
               instr_valid_d = 1'b0;
               // A misaligned target parks the core with the PC of the faulting instruction.
               if (target_misaligned) begin
                  misaligned_d = 1'b1;
                  state_d      = StFault;
               end else begin
                  pc_d       = target;
                  imem_req_d = 1'b1;
                  state_d    = StFetch;
               end
            end
         end
         StFault: begin
            state_d = StFault;
         end
         default: begin
            state_d = StFault;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         pc_q          <= RESET_PC;
         instr_q       <= NOP_INSTR;
         instr_valid_q <= 1'b0;
         imem_req_q    <= 1'b0;
         misaligned_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         imem_req_q    <= imem_req_d;
         misaligned_q  <= misaligned_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = pc_q;
   assign instruction = instr_q;
   assign instr_valid = instr_valid_q;
   assign pc          = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign misaligned  = misaligned_q;

endmodule
